// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default counter width and the meter FSM state encoding.
package pwm_pkg;

    localparam int PWM_CNT_W = 20;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM input conditioning: 2-FF synchronizer followed by an optional glitch filter.
// The filter is compiled in when PWM_METER_FILTER_EN is defined.
module pwm_in_cond #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic sig
);

`ifdef PWM_METER_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic [1:0] sync_r;

    // Two-stage synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pwm_in};
        end
    end

    if (FILTER_ON && (FILT_LEN > 0)) begin : g_filt
        localparam int FW = $clog2(FILT_LEN + 1);
        logic [FW-1:0] filt_cnt_r;
        logic          sig_r;

        // Accept a new level only after it has held for FILT_LEN consecutive cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_cnt_r <= '0;
                sig_r      <= 1'b0;
            end else if (sync_r[1] == sig_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILT_LEN - 1)) begin
                filt_cnt_r <= '0;
                sig_r      <= sync_r[1];
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end

        assign sig = sig_r;
    end else begin : g_pass
        assign sig = sync_r[1];
    end

endmodule

// File: rtl/pwm_meter.sv
// PWM capture: measures period and high time between rising edges, flags a stalled input.
// Optional glitch filter in pwm_in_cond is enabled by defining PWM_METER_FILTER_EN.
module pwm_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W    = PWM_CNT_W,
    parameter int TIMEOUT  = 999_999,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    logic             sig_s;
    logic             sig_d_r;
    logic             rise_s;
    meter_state_t     state_r,    state_nx_s;
    logic [CNT_W-1:0] per_cnt_r,  per_cnt_nx_s;
    logic [CNT_W-1:0] hi_cnt_r,   hi_cnt_nx_s;
    logic [CNT_W-1:0] period_r,   period_nx_s;
    logic [CNT_W-1:0] high_r,     high_nx_s;
    logic             valid_r,    valid_nx_s;
    logic             timeout_r,  timeout_nx_s;
    logic             level_r;

    pwm_in_cond #(
        .FILT_LEN (FILT_LEN)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .sig    (sig_s)
    );

    assign rise_s = sig_s & ~sig_d_r;

    // Next-state, counter and result logic; the first rise after IDLE only arms the counters.
    always_comb begin
        state_nx_s   = state_r;
        per_cnt_nx_s = per_cnt_r;
        hi_cnt_nx_s  = hi_cnt_r;
        period_nx_s  = period_r;
        high_nx_s    = high_r;
        valid_nx_s   = 1'b0;
        timeout_nx_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    per_cnt_nx_s = CNT_W'(1);
                    hi_cnt_nx_s  = CNT_W'(1);
                    timeout_nx_s = 1'b0;
                    state_nx_s   = ST_MEASURE;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A rise on the TIMEOUT cycle is still a valid measurement.
                if (rise_s) begin
                    period_nx_s  = per_cnt_r;
                    high_nx_s    = hi_cnt_r;
                    valid_nx_s   = 1'b1;
                    per_cnt_nx_s = CNT_W'(1);
                    hi_cnt_nx_s  = CNT_W'(1);
                end else if (per_cnt_r == CNT_W'(TIMEOUT)) begin
                    timeout_nx_s = 1'b1;
                    state_nx_s   = ST_IDLE;
                end else begin
                    per_cnt_nx_s = per_cnt_r + CNT_W'(1);
                    hi_cnt_nx_s  = hi_cnt_r + CNT_W'(sig_s);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sig_d_r   <= 1'b0;
            per_cnt_r <= '0;
            hi_cnt_r  <= '0;
            period_r  <= '0;
            high_r    <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            level_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            sig_d_r   <= sig_s;
            per_cnt_r <= per_cnt_nx_s;
            hi_cnt_r  <= hi_cnt_nx_s;
            period_r  <= period_nx_s;
            high_r    <= high_nx_s;
            valid_r   <= valid_nx_s;
            timeout_r <= timeout_nx_s;
            level_r   <= sig_s;
        end
    end

    assign period     = period_r;
    assign high       = high_r;
    assign meas_valid = valid_r;
    assign timeout    = timeout_r;
    assign level      = level_r;

endmodule
